// File: rtl/gf180mcu_fd_sc_mcu9t5v0_pwrsw_pkg.sv
// Shared types and helpers for the header-switch enable sequencer.
// Holds the FSM state encoding and the counter-width function.
package gf180mcu_fd_sc_mcu9t5v0_pwrsw_pkg;

    typedef enum logic [2:0] {
        PS_OFF       = 3'd0,
        PS_RAMP_UP   = 3'd1,
        PS_WAIT_ACK  = 3'd2,
        PS_ON        = 3'd3,
        PS_RAMP_DOWN = 3'd4
    } pwrsw_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_pwrsw_sync2.sv
// Two-flop synchronizer for the asynchronous switch-chain acknowledge.
// Both stages clear to 0 on the asynchronous active-high reset.
module gf180mcu_fd_sc_mcu9t5v0_pwrsw_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_pwrsw_seq.sv
// Staggered power-switch enable sequencer: ramps thermometer-coded group
// enables up/down, waits for chain acknowledge, then drives power-good/isolation.
module gf180mcu_fd_sc_mcu9t5v0_pwrsw_seq
    import gf180mcu_fd_sc_mcu9t5v0_pwrsw_pkg::*;
#(
    parameter int N_GROUPS    = 8,
    parameter int STEP_CYCLES = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PWR_REQ,
    input  logic                SW_ACK,
    output logic [N_GROUPS-1:0] SW_EN,
    output logic                ISO,
    output logic                PWR_GOOD,
    output logic                BUSY,
    output logic                ERR,
    output pwrsw_state_t        STATE_DBG
);

    localparam int STEP_W = cnt_width(STEP_CYCLES - 1);
    localparam int TMO_W  = cnt_width(ACK_TIMEOUT);

    localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX     = TMO_W'(ACK_TIMEOUT);

    pwrsw_state_t        state_q;
    pwrsw_state_t        state_d;
    logic [N_GROUPS-1:0] sw_en_q;
    logic [N_GROUPS-1:0] sw_en_d;
    logic [STEP_W-1:0]   step_q;
    logic [STEP_W-1:0]   step_d;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    tmo_d;
    logic                iso_q;
    logic                iso_d;
    logic                pg_q;
    logic                pg_d;
    logic                err_q;
    logic                err_d;
    logic                ack_s;

    gf180mcu_fd_sc_mcu9t5v0_pwrsw_sync2 u_ack_sync (
        .clk (CLK),
        .rst (RST),
        .d   (SW_ACK),
        .q   (ack_s)
    );

    always_comb begin
        state_d = state_q;
        sw_en_d = sw_en_q;
        step_d  = step_q;
        tmo_d   = tmo_q;
        iso_d   = iso_q;
        pg_d    = pg_q;
        err_d   = err_q;

        case (state_q)
            PS_OFF: begin
                if (!PWR_REQ) begin
                    err_d = 1'b0;
                end else if (!err_q) begin
                    sw_en_d = N_GROUPS'(1);
                    step_d  = STEP_RELOAD;
                    state_d = PS_RAMP_UP;
                end
            end

            PS_RAMP_UP: begin
                if (!PWR_REQ) begin
                    // Zeroed step counter makes the first bit drop one edge later.
                    step_d  = '0;
                    state_d = PS_RAMP_DOWN;
                end else if (step_q == '0) begin
                    sw_en_d = {sw_en_q[N_GROUPS-2:0], 1'b1};
                    step_d  = STEP_RELOAD;
                    if (sw_en_q[N_GROUPS-2]) begin
                        tmo_d   = '0;
                        state_d = PS_WAIT_ACK;
                    end
                end else begin
                    step_d = step_q - 1'b1;
                end
            end

            PS_WAIT_ACK: begin
                if (!PWR_REQ) begin
                    step_d  = '0;
                    state_d = PS_RAMP_DOWN;
                end else if (ack_s) begin
                    pg_d    = 1'b1;
                    state_d = PS_ON;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = TMO_MAX;
                    err_d   = 1'b1;
                    step_d  = '0;
                    state_d = PS_RAMP_DOWN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            PS_ON: begin
                if (!PWR_REQ) begin
                    iso_d   = 1'b1;
                    pg_d    = 1'b0;
                    step_d  = '0;
                    state_d = PS_RAMP_DOWN;
                end else begin
                    // Releases isolation one edge after power-good rose.
                    iso_d = 1'b0;
                end
            end

            PS_RAMP_DOWN: begin
                if (PWR_REQ && !err_q) begin
                    if (&sw_en_q) begin
                        tmo_d   = '0;
                        state_d = PS_WAIT_ACK;
                    end else begin
                        step_d  = STEP_RELOAD;
                        state_d = PS_RAMP_UP;
                    end
                end else if (step_q == '0) begin
                    sw_en_d = sw_en_q >> 1;
                    step_d  = STEP_RELOAD;
                    if (!sw_en_q[1]) begin
                        state_d = PS_OFF;
                    end
                end else begin
                    step_d = step_q - 1'b1;
                end
            end

            default: begin
                state_d = PS_OFF;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= PS_OFF;
            sw_en_q <= '0;
            step_q  <= '0;
            tmo_q   <= '0;
            iso_q   <= 1'b1;
            pg_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sw_en_q <= sw_en_d;
            step_q  <= step_d;
            tmo_q   <= tmo_d;
            iso_q   <= iso_d;
            pg_q    <= pg_d;
            err_q   <= err_d;
        end
    end

    assign SW_EN     = sw_en_q;
    assign ISO       = iso_q;
    assign PWR_GOOD  = pg_q;
    assign ERR       = err_q;
    assign BUSY      = (state_q == PS_RAMP_UP) || (state_q == PS_WAIT_ACK) ||
                       (state_q == PS_RAMP_DOWN);
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_pwrsw_seq.sv
// Bench for the power-switch sequencer: directed timing scenarios plus a
// randomized run against an event-time reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0_pwrsw_seq;
  import gf180mcu_fd_sc_mcu9t5v0_pwrsw_pkg::*;

  localparam int N = 4;
  localparam int S = 4;
  localparam int T = 20;

  localparam int M_OFF  = 0;
  localparam int M_UP   = 1;
  localparam int M_WAIT = 2;
  localparam int M_ON   = 3;
  localparam int M_DOWN = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         PWR_REQ;
  logic         SW_ACK;
  logic [N-1:0] SW_EN;
  logic         ISO;
  logic         PWR_GOOD;
  logic         BUSY;
  logic         ERR;
  pwrsw_state_t state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Reference model: groups-on count plus absolute edge numbers of the
  // next scheduled step and of the acknowledge deadline.
  int m_mode;
  int m_lvl;
  int m_next;
  int m_deadline;
  bit m_iso;
  bit m_pg;
  bit m_err;
  bit ack_pipe[$];
  logic [7:0] exp_q[$];

  gf180mcu_fd_sc_mcu9t5v0_pwrsw_seq #(
    .N_GROUPS    (N),
    .STEP_CYCLES (S),
    .ACK_TIMEOUT (T)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PWR_REQ   (PWR_REQ),
    .SW_ACK    (SW_ACK),
    .SW_EN     (SW_EN),
    .ISO       (ISO),
    .PWR_GOOD  (PWR_GOOD),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .STATE_DBG (state_dbg)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF;
    m_lvl = 0;
    m_next = 0;
    m_deadline = 0;
    m_iso = 1'b1;
    m_pg = 1'b0;
    m_err = 1'b0;
    ack_pipe.delete();
    ack_pipe.push_back(1'b0);
    ack_pipe.push_back(1'b0);
    exp_q.delete();
  endtask

  task automatic model_step();
    bit req;
    bit ack_used;
    logic [N-1:0] exp_sw;
    bit exp_busy;
    req = PWR_REQ;
    ack_used = ack_pipe.pop_front();
    ack_pipe.push_back(SW_ACK);
    case (m_mode)
      M_OFF: begin
        if (!req) m_err = 1'b0;
        else if (!m_err) begin
          m_lvl = 1;
          m_next = edge_n + S;
          m_mode = M_UP;
        end
      end
      M_UP: begin
        if (!req) begin
          m_mode = M_DOWN;
          m_next = edge_n + 1;
        end else if (edge_n == m_next) begin
          m_lvl++;
          m_next = edge_n + S;
          if (m_lvl == N) begin
            m_mode = M_WAIT;
            m_deadline = edge_n + T;
          end
        end
      end
      M_WAIT: begin
        if (!req) begin
          m_mode = M_DOWN;
          m_next = edge_n + 1;
        end else if (ack_used) begin
          m_mode = M_ON;
          m_pg = 1'b1;
        end else if (edge_n == m_deadline) begin
          m_err = 1'b1;
          m_mode = M_DOWN;
          m_next = edge_n + 1;
        end
      end
      M_ON: begin
        if (!req) begin
          m_iso = 1'b1;
          m_pg = 1'b0;
          m_mode = M_DOWN;
          m_next = edge_n + 1;
        end else begin
          m_iso = 1'b0;
        end
      end
      default: begin
        if (req && !m_err) begin
          if (m_lvl == N) begin
            m_mode = M_WAIT;
            m_deadline = edge_n + T;
          end else begin
            m_mode = M_UP;
            m_next = edge_n + S;
          end
        end else if (edge_n == m_next) begin
          m_lvl--;
          m_next = edge_n + S;
          if (m_lvl == 0) m_mode = M_OFF;
        end
      end
    endcase
    exp_sw = N'((1 << m_lvl) - 1);
    exp_busy = (m_mode == M_UP) || (m_mode == M_WAIT) || (m_mode == M_DOWN);
    exp_q.push_back({exp_sw, m_iso, m_pg, exp_busy, m_err});
  endtask

  task automatic check_outputs();
    logic [7:0] e;
    e = exp_q.pop_front();
    check_val("sw_en", 32'(SW_EN), 32'(e[7:4]));
    check_val("iso", 32'(ISO), 32'(e[3]));
    check_val("pwr_good", 32'(PWR_GOOD), 32'(e[2]));
    check_val("busy", 32'(BUSY), 32'(e[1]));
    check_val("err", 32'(ERR), 32'(e[0]));
  endtask

  task automatic tick();
    @(posedge CLK);
    edge_n++;
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called 1 time unit after an edge; reset lands and clears before the next edge.
  task automatic pulse_reset(input string tag);
    #3 RST = 1'b1;
    #1;
    check_val({tag, "_sw_en"}, 32'(SW_EN), 32'h0);
    check_val({tag, "_iso"}, 32'(ISO), 32'h1);
    check_val({tag, "_pwr_good"}, 32'(PWR_GOOD), 32'h0);
    check_val({tag, "_busy"}, 32'(BUSY), 32'h0);
    check_val({tag, "_err"}, 32'(ERR), 32'h0);
    #1 RST = 1'b0;
    model_reset();
  endtask

  initial begin
    RST = 1'b1;
    PWR_REQ = 1'b0;
    SW_ACK = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_sw_en", 32'(SW_EN), 32'h0);
    check_val("rst_iso", 32'(ISO), 32'h1);
    check_val("rst_pwr_good", 32'(PWR_GOOD), 32'h0);
    check_val("rst_busy", 32'(BUSY), 32'h0);
    check_val("rst_err", 32'(ERR), 32'h0);
    check_val("rst_state", 32'(state_dbg), 32'(PS_OFF));
    @(negedge CLK);
    RST = 1'b0;
    tick_n(3);

    // power-up: request sampled at edge k
    PWR_REQ = 1'b1;
    tick();
    check_val("up_k0", 32'(SW_EN), 32'b0001);
    tick_n(4); check_val("up_k4", 32'(SW_EN), 32'b0011);
    tick_n(4); check_val("up_k8", 32'(SW_EN), 32'b0111);
    tick_n(4); check_val("up_k12", 32'(SW_EN), 32'b1111);
    check_val("up_wait_state", 32'(state_dbg), 32'(PS_WAIT_ACK));
    tick_n(2);
    SW_ACK = 1'b1;
    tick_n(2); check_val("ack_pg_early", 32'(PWR_GOOD), 32'h0);
    tick();
    check_val("ack_pg", 32'(PWR_GOOD), 32'h1);
    check_val("ack_busy", 32'(BUSY), 32'h0);
    check_val("ack_iso_hold", 32'(ISO), 32'h1);
    tick(); check_val("ack_iso_rel", 32'(ISO), 32'h0);

    // power-down from ON
    tick_n(3);
    PWR_REQ = 1'b0;
    SW_ACK = 1'b0;
    tick();
    check_val("dn_iso", 32'(ISO), 32'h1);
    check_val("dn_pg", 32'(PWR_GOOD), 32'h0);
    check_val("dn_sw_hold", 32'(SW_EN), 32'b1111);
    tick(); check_val("dn_e1", 32'(SW_EN), 32'b0111);
    tick_n(4); check_val("dn_e5", 32'(SW_EN), 32'b0011);
    tick_n(4); check_val("dn_e9", 32'(SW_EN), 32'b0001);
    tick_n(4); check_val("dn_e13", 32'(SW_EN), 32'b0000);
    check_val("dn_busy", 32'(BUSY), 32'h0);

    // abort during ramp-up
    tick_n(2);
    PWR_REQ = 1'b1;
    tick();
    tick_n(4);
    PWR_REQ = 1'b0;
    tick(); check_val("ab_k5", 32'(SW_EN), 32'b0011);
    tick(); check_val("ab_k6", 32'(SW_EN), 32'b0001);
    tick_n(4);
    check_val("ab_k10", 32'(SW_EN), 32'b0000);
    check_val("ab_pg", 32'(PWR_GOOD), 32'h0);

    // reversal during ramp-down
    tick_n(2);
    PWR_REQ = 1'b1;
    SW_ACK = 1'b1;
    tick_n(17);
    check_val("rv_on", 32'(PWR_GOOD), 32'h1);
    PWR_REQ = 1'b0;
    tick();
    tick();
    tick_n(4); check_val("rv_e5", 32'(SW_EN), 32'b0011);
    PWR_REQ = 1'b1;
    tick(); check_val("rv_e6", 32'(SW_EN), 32'b0011);
    tick_n(4); check_val("rv_e10", 32'(SW_EN), 32'b0111);
    tick_n(4); check_val("rv_e14", 32'(SW_EN), 32'b1111);
    check_val("rv_state", 32'(state_dbg), 32'(PS_WAIT_ACK));
    tick(); check_val("rv_pg", 32'(PWR_GOOD), 32'h1);
    PWR_REQ = 1'b0;
    SW_ACK = 1'b0;
    tick_n(16);

    // acknowledge timeout
    PWR_REQ = 1'b1;
    tick();
    tick_n(31); check_val("to_k31_err", 32'(ERR), 32'h0);
    tick();
    check_val("to_k32_err", 32'(ERR), 32'h1);
    check_val("to_k32_sw", 32'(SW_EN), 32'b1111);
    tick(); check_val("to_k33", 32'(SW_EN), 32'b0111);
    tick_n(12);
    check_val("to_k45", 32'(SW_EN), 32'b0000);
    check_val("to_off_busy", 32'(BUSY), 32'h0);
    tick_n(5);
    check_val("to_block_err", 32'(ERR), 32'h1);
    check_val("to_block_sw", 32'(SW_EN), 32'b0000);
    PWR_REQ = 1'b0;
    tick(); check_val("to_clear", 32'(ERR), 32'h0);

    // asynchronous reset with SW_EN=0111 and ERR set
    PWR_REQ = 1'b1;
    tick();
    tick_n(33);
    check_val("ar_pre_sw", 32'(SW_EN), 32'b0111);
    check_val("ar_pre_err", 32'(ERR), 32'h1);
    PWR_REQ = 1'b0;
    pulse_reset("ar");
    tick_n(2);

    // randomized run
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) PWR_REQ = ~PWR_REQ;
      if ($urandom_range(0, 5) == 0) SW_ACK = ~SW_ACK;
      if ($urandom_range(0, 399) == 0) pulse_reset("rnd_rst");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0_pwrsw_seq.md
# gf180mcu_fd_sc_mcu9t5v0_pwrsw_seq

Power-switch enable sequencer for switchable domains built from the 9-track library. The sequencer ramps daisy-chained header-switch groups on and off in staggered steps to bound inrush current while fillcap decoupling holds the rail. It waits for the chain acknowledge, then raises power-good and releases isolation. It sits directly upstream of the switch/decap row and drives the per-group switch enables.

## Interface
Parameters:
- N_GROUPS, 8: number of switch groups; legal range 2..32.
- STEP_CYCLES, 16: CLK cycles between successive group enables/disables; must be ≥1.
- ACK_TIMEOUT, 255: maximum cycles to wait in WAIT_ACK before flagging an error; must be ≥1.

Ports:
- CLK  input  1  sole clock.
- RST  input  1  asynchronous, active-high reset.
- PWR_REQ  input  1  domain power request; synchronous to CLK.
- SW_ACK  input  1  acknowledge from the last switch in the chain; asynchronous.
- SW_EN  output  N_GROUPS  per-group switch enables, thermometer coded from bit 0.
- ISO  output  1  isolation enable, active high.
- PWR_GOOD  output  1  domain powered and stable.
- BUSY  output  1  high in RAMP_UP, WAIT_ACK or RAMP_DOWN.
- ERR  output  1  sticky acknowledge-timeout flag.

## Operation
- States: OFF, RAMP_UP, WAIT_ACK, ON, RAMP_DOWN.
- Reset values: state OFF, SW_EN=0, ISO=1, PWR_GOOD=0, BUSY=0, ERR=0.
- SW_ACK passes through a 2-flop synchronizer. Only the synchronized value (ack_s) is used.
- OFF, PWR_REQ=1 and ERR=0:
  - At the same edge: SW_EN[0]=1, step counter loads STEP_CYCLES-1, go to RAMP_UP.
- OFF, PWR_REQ=0: ERR clears.
- RAMP_UP:
  - When the counter reaches 0, set the next SW_EN bit and reload the counter.
  - At the edge that sets the top bit, go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - ack_s=1: go to ON and set PWR_GOOD=1. ISO goes to 0 one edge later.
  - Timeout counter reaches ACK_TIMEOUT: set ERR=1 and go to RAMP_DOWN.
- ON, PWR_REQ=0: at that edge, ISO=1, PWR_GOOD=0, go to RAMP_DOWN.
- RAMP_DOWN:
  - The highest set bit clears one edge after entry, then one more bit every STEP_CYCLES.
  - At the edge SW_EN becomes 0, go to OFF.
- PWR_REQ=0 during RAMP_UP or WAIT_ACK: go to RAMP_DOWN from the current SW_EN. No further bit is added at that edge.
- PWR_REQ=1 during RAMP_DOWN, ERR=0: go to RAMP_UP from the current SW_EN. The counter reloads STEP_CYCLES-1, and the next bit is added when it reaches 0.
- ERR=1 blocks power-up. The block stays in OFF until PWR_REQ is sampled low.
- SW_EN is always thermometer coded; no bit above a zero bit is ever set.

## Timing
- SW_EN[i] rises at edge k + i·STEP_CYCLES, where k is the edge at which PWR_REQ=1 is sampled in OFF.
- SW_ACK to ON: 3 edges (2 synchronizer edges plus the FSM edge).
- ISO deassertion lags PWR_GOOD assertion by exactly 1 cycle.
- On power-down, ISO asserts and PWR_GOOD drops at the same edge, before any switch is disabled.
- Step counter width: $clog2(STEP_CYCLES), minimum 1. Timeout counter width: $clog2(ACK_TIMEOUT+1). Counters saturate and never wrap.
- STEP_CYCLES=1: one group changes per edge.
- RST asserted mid-operation: every output takes its reset value immediately, so all switches drop together. This is accepted behaviour.

## Structure
- Package gf180mcu_fd_sc_mcu9t5v0_pwrsw_pkg holds:
  - the state enum (pwrsw_state_t);
  - a localparam function for counter widths.
- Sub-module gf180mcu_fd_sc_mcu9t5v0_pwrsw_sync2: 2-flop synchronizer with asynchronous active-high reset to 0.
- The top level holds the FSM, the step counter, the timeout counter and the SW_EN shift register.

## Test plan
All cases use N_GROUPS=4, STEP_CYCLES=4, ACK_TIMEOUT=20.
1. Power-up: PWR_REQ=1 sampled at edge 10 -> SW_EN=0001@10, 0011@14, 0111@18, 1111@22. SW_ACK=1 before edge 25 -> PWR_GOOD=1@27, ISO=0@28, BUSY=0@27.
2. Timeout: as case 1 but SW_ACK held 0 -> ERR=1@42, SW_EN=0111@43, 0011@47, 0001@51, 0000@55. PWR_REQ held 1 leaves the block in OFF with ERR=1. PWR_REQ=0 sampled -> ERR=0 at that edge.
3. Power-down from ON: PWR_REQ=0 sampled at edge 50 -> ISO=1 and PWR_GOOD=0@50, SW_EN=0111@51, 0011@55, 0001@59, 0000@63, BUSY=0@63.
4. Abort during ramp-up: PWR_REQ=0 sampled at edge 15 (SW_EN=0011) -> SW_EN=0001@16, 0000@20. ISO stays 1 and PWR_GOOD stays 0 throughout.
5. Reversal during ramp-down: PWR_REQ=1 sampled at edge 56 (SW_EN=0011) -> SW_EN=0111@60, 1111@64, then WAIT_ACK.
6. Asynchronous reset: RST pulsed between edges with SW_EN=0111 -> SW_EN=0, ISO=1, PWR_GOOD=0, ERR=0 immediately, before the next edge.
